dcache_direct_wb: RTL and testbench

//  Responder side of the core's D-cache interface (ren/wen/addr/wdata -> stall/rdata).

---
 rtl/dcache_direct_wb.sv | 115 +++++++++++
 tb/tb_dcache_direct_wb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits are zero-latency; misses stall the core while it writes back and refills over a ready handshake.
module dcache_direct_wb #(
   parameter int NUM_BLOCKS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);
   // state     | meaning
   // IDLE      | serving hits; a miss picks WRITEBACK (dirty victim) or ALLOCATE
   // WRITEBACK | dirty victim line sent to memory, waiting for mem_ready
   // ALLOCATE  | refill of the requested block, waiting for mem_ready
   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
   state_t state;

   logic [NUM_BLOCKS-1:0] valid;
   logic [NUM_BLOCKS-1:0] dirty;
   logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
   logic [127:0]          data_mem [NUM_BLOCKS];

   logic [1:0]       offset;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             req;
   logic             hit;
   logic             write_hit;
   logic             refill;

   assign offset    = proc_addr[1:0];
   assign idx       = proc_addr[IDX_W+1:2];
   assign tag       = proc_addr[29:IDX_W+2];
   assign req       = proc_read | proc_write;
   assign hit       = valid[idx] && (tag_mem[idx] == tag);
   assign write_hit = (state == IDLE) && proc_write && hit;
   assign refill    = (state == ALLOCATE) && mem_ready;

   assign proc_stall = (state != IDLE) || (req && !hit);
   assign proc_rdata = ((state == IDLE) && hit && proc_read) ?
                       data_mem[idx][{offset, 5'b0} +: 32] : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         valid     <= '0;
         dirty     <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (proc_write && hit) begin
                  dirty[idx] <= 1'b1;
               end else if (req && !hit) begin
                  if (valid[idx] && dirty[idx]) begin
                     state     <= WRITEBACK;
                     mem_write <= 1'b1;
                     mem_addr  <= {tag_mem[idx], idx};
                     mem_wdata <= data_mem[idx];
                  end else begin
                     state    <= ALLOCATE;
                     mem_read <= 1'b1;
                     mem_addr <= proc_addr[29:2];
                  end
               end
            end
            WRITEBACK: begin
               // hand straight over to the refill so the two requests never overlap
               if (mem_ready) begin
                  state      <= ALLOCATE;
                  dirty[idx] <= 1'b0;
                  mem_write  <= 1'b0;
                  mem_read   <= 1'b1;
                  mem_addr   <= proc_addr[29:2];
               end
            end
            ALLOCATE: begin
               if (mem_ready) begin
                  state      <= IDLE;
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
                  mem_read   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // tags and data are only meaningful under valid, so they carry no reset
   always_ff @(posedge clk) begin
      if (refill) begin
         data_mem[idx] <= mem_rdata;
         tag_mem[idx]  <= tag;
      end else if (write_hit) begin
         data_mem[idx][{offset, 5'b0} +: 32] <= proc_wdata;
      end
   end
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed and random checks of dcache_direct_wb against a word-level reference memory.
// The bench itself plays the block memory, with configurable response latency.
module tb_dcache_direct_wb;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         proc_read = 1'b0;
   logic         proc_write = 1'b0;
   logic [29:0]  proc_addr = '0;
   logic [31:0]  proc_wdata = '0;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   dcache_direct_wb #(.NUM_BLOCKS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int stall_cycles;
   logic [31:0]  exp_q [$];
   logic [127:0] bmem [logic [27:0]];
   logic [31:0]  ref_mem [logic [29:0]];
   bit           ev_wr [$];
   logic [27:0]  ev_addr [$];
   logic [127:0] ev_data [$];

   function automatic logic [127:0] init_block(input logic [27:0] b);
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[32*i +: 32] = {i[1:0], 2'b10, b};
      return v;
   endfunction

   function automatic logic [127:0] bmem_get(input logic [27:0] b);
      return bmem.exists(b) ? bmem[b] : init_block(b);
   endfunction

   function automatic logic [31:0] model_read(input logic [29:0] a);
      logic [127:0] blk;
      if (ref_mem.exists(a)) return ref_mem[a];
      blk = bmem_get(a[29:2]);
      return blk[{a[1:0], 5'b0} +: 32];
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_events();
      ev_wr.delete();
      ev_addr.delete();
      ev_data.delete();
   endtask

   // called at a falling edge; drives one request and acts as memory until the core is released
   task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                         input logic [31:0] wd, input int lat_min, input int lat_max);
      int cnt;
      int lat;
      bit done;
      logic [31:0] e;
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = wd;
      if (rd && !wr) exp_q.push_back(model_read(a));
      lat = $urandom_range(lat_max, lat_min);
      cnt = 0;
      done = 0;
      stall_cycles = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         #1;
         chk("no_overlap", {1'b0, mem_read & mem_write}, 2'b00);
         if (!proc_stall) begin
            chk("released_no_mem_req", {mem_read, mem_write}, 2'b00);
            if (rd && !wr) begin
               e = exp_q.pop_front();
               chk("rdata", proc_rdata, e);
            end
            if (wr) ref_mem[a] = wd;
            done = 1;
         end else begin
            stall_cycles++;
            if (mem_read || mem_write) begin
               cnt++;
               if (cnt >= lat) begin
                  mem_ready = 1'b1;
                  ev_wr.push_back(mem_write);
                  ev_addr.push_back(mem_addr);
                  ev_data.push_back(mem_wdata);
                  if (mem_write) bmem[mem_addr] = mem_wdata;
                  else mem_rdata = bmem_get(mem_addr);
                  cnt = 0;
                  lat = $urandom_range(lat_max, lat_min);
               end
            end
         end
         @(posedge clk);
         @(negedge clk);
         mem_ready = 1'b0;
      end
      chk("access_done", {7'b0, done}, 8'd1);
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d;
      logic [29:0]  a;
      int           mode;
      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", {7'b0, proc_stall}, 8'd0);
      chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
      chk("rst_mem_addr", mem_addr, 28'h0);
      chk("rst_mem_wdata", mem_wdata, 128'h0);
      chk("rst_rdata", proc_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // T1 cold read miss, memory answers on the third request cycle
      clear_events();
      access(1, 0, 30'h5, 32'h0, 3, 3);
      chk("t1_stall_cycles", stall_cycles, 4);
      chk("t1_ev_count", ev_wr.size(), 1);
      chk("t1_ev_is_read", {7'b0, ev_wr[0]}, 8'd0);
      chk("t1_ev_addr", ev_addr[0], 28'h1);

      // T2 write hit, then read back
      clear_events();
      access(0, 1, 30'h5, 32'hDEAD_BEEF, 1, 1);
      chk("t2_write_stall", stall_cycles, 0);
      chk("t2_ev_count", ev_wr.size(), 0);
      access(1, 0, 30'h5, 32'h0, 1, 1);
      chk("t2_read_stall", stall_cycles, 0);
      #1;
      chk("t2_idle_rdata", proc_rdata, 32'h0);

      // T3 dirty eviction by a conflicting read
      clear_events();
      access(1, 0, 30'h25, 32'h0, 1, 1);
      chk("t3_stall_cycles", stall_cycles, 3);
      chk("t3_ev_count", ev_wr.size(), 2);
      chk("t3_wb_is_write", {7'b0, ev_wr[0]}, 8'd1);
      chk("t3_wb_addr", ev_addr[0], 28'h1);
      d = ev_data[0];
      chk("t3_wb_word1", d[63:32], 32'hDEAD_BEEF);
      chk("t3_fill_is_read", {7'b0, ev_wr[1]}, 8'd0);
      chk("t3_fill_addr", ev_addr[1], 28'h9);

      // T4 write miss to a clean line, then prove it became dirty
      clear_events();
      access(0, 1, 30'h40, 32'h1234_5678, 2, 2);
      chk("t4_stall_cycles", stall_cycles, 3);
      chk("t4_ev_count", ev_wr.size(), 1);
      chk("t4_fill_addr", ev_addr[0], 28'h10);
      access(1, 0, 30'h40, 32'h0, 1, 1);
      chk("t4_read_hit_stall", stall_cycles, 0);
      clear_events();
      access(1, 0, 30'h0, 32'h0, 1, 1);
      chk("t4_evict_count", ev_wr.size(), 2);
      chk("t4_evict_is_write", {7'b0, ev_wr[0]}, 8'd1);
      chk("t4_evict_addr", ev_addr[0], 28'h10);
      d = ev_data[0];
      chk("t4_evict_word0", d[31:0], 32'h1234_5678);

      // T5 reset while a refill is outstanding
      proc_read = 1'b1;
      proc_addr = 30'h45;
      for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
      #1;
      chk("t5_mem_read_before", {7'b0, mem_read}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_mem_rw_in_reset", {mem_read, mem_write}, 2'b00);
      chk("t5_mem_addr_in_reset", mem_addr, 28'h0);
      proc_read = 1'b0;
      ref_mem.delete();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_events();
      access(1, 0, 30'h5, 32'h0, 2, 2);
      chk("t5_remiss", {7'b0, stall_cycles > 0}, 8'd1);
      chk("t5_ev_is_read", {7'b0, ev_wr[0]}, 8'd0);
      chk("t5_ev_addr", ev_addr[0], 28'h1);

      // T6 random traffic, simultaneous read+write, spurious ready in IDLE
      for (int n = 0; n < 60; n++) begin
         if (n % 5 == 0) begin
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            chk("t6_spurious_rw", {mem_read, mem_write}, 2'b00);
            chk("t6_spurious_stall", {7'b0, proc_stall}, 8'd0);
            @(negedge clk);
         end
         a = 30'($urandom_range(3, 0)) << 5;
         a = a | (30'($urandom_range(7, 0)) << 2) | 30'($urandom_range(3, 0));
         mode = $urandom_range(2, 0);
         access(mode != 1, mode != 0, a, $urandom, 1, 20);
      end
      for (int k = 0; k < 32; k++) begin
         access(1, 0, 30'(k * 3 + 1) & 30'h7F, 32'h0, 1, 5);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
